vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 Parameter CLK_DIV, default 2: clk cycles per pixel; legal values are 1 to 16.
REQ-010 The block SHALL use one clock and an asynchronous active-low reset, with ports clk and reset_n.
REQ-011 clk  input  1  system clock.
REQ-012 reset_n  input  1  asynchronous active-low reset.
REQ-013 pix_tick  output  1  one-clk strobe marking the first cycle of each new pixel position.
REQ-014 hcount  output  10  horizontal position, 0 to H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-015 vcount  output  10  vertical position, 0 to V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-016 hsync  output  1  horizontal sync, active low.
REQ-017 vsync  output  1  vertical sync, active low.
REQ-018 video_on  output  1  high while the current position is inside the visible area.
REQ-019 line_start  output  1  one-clk pulse when hcount becomes 0.
REQ-020 frame_start  output  1  one-clk pulse when hcount and vcount both become 0.
REQ-021 frame_count  output  8  count of completed frames, wrapping.

Function
REQ-022 An internal divider SHALL count 0 to CLK_DIV-1 and wrap; its terminal value is CLK_DIV-1.
REQ-023 On the clk edge where the divider is at its terminal value, the counters SHALL advance and pix_tick SHALL be registered high for exactly the following cycle.
REQ-024 pix_tick SHALL be low on all other cycles; with CLK_DIV=1, pix_tick SHALL be constantly high after the first clk edge.
REQ-025 hcount SHALL advance by 1 on each advance, and wrap from H_TOTAL-1 to 0.
REQ-026 vcount SHALL increment only when hcount wraps, and wrap from V_TOTAL-1 to 0 on that same edge.
REQ-027 Outputs are a registered decode of the next counter values, so hsync, vsync, video_on, line_start and frame_start SHALL always match the hcount/vcount presented in the same cycle, with no one-cycle skew.
REQ-028 hsync SHALL be 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
REQ-029 vsync SHALL be 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults).
REQ-030 video_on SHALL be 1 iff hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-031 line_start SHALL be high only in the pix_tick cycle in which hcount became 0 by wrap.
REQ-032 frame_start SHALL be high only in the pix_tick cycle in which the counters became (0,0) by wrap.
REQ-033 frame_count SHALL increment on that same edge and wrap from 255 to 0.
REQ-034 With hcount and vcount both at their maximum, the single advancing edge SHALL wrap both counters, pulse line_start and frame_start together, and increment frame_count.
REQ-035 Counter arithmetic SHALL be 10-bit unsigned; H_TOTAL and V_TOTAL must not exceed 1024.

Reset
REQ-036 While reset_n=0, the divider SHALL be 0, and hcount=0, vcount=0, frame_count=0, pix_tick=0, line_start=0, frame_start=0.
REQ-037 While reset_n=0, the decode outputs SHALL be consistent with position (0,0): hsync=1, vsync=1, video_on=1.
REQ-038 Assertion of reset_n at any point, including mid-line, mid-sync or mid-divide, SHALL force all REQ-036/037 values immediately, without waiting for a clk edge.
REQ-039 After reset_n deasserts, the first counter advance SHALL occur at clk edge CLK_DIV, presenting hcount=1 with pix_tick=1 and no line_start or frame_start pulse.

Verification
REQ-040 Defaults, release reset: edge 1 -> hcount=0, pix_tick=0; edge 2 -> hcount=1, pix_tick=1; pix_tick then has period 2 clk, duty 1 clk.
REQ-041 Run one line: hsync=0 for exactly 96 ticks starting at hcount=656; video_on falls at hcount=640; line_start rises with vcount=1 after 800 ticks (1600 clk).
REQ-042 Run one frame: vsync=0 exactly while vcount is 490..491 (1600 ticks); frame_start fires with (0,0) after 420000 ticks, and frame_count becomes 1.
REQ-043 Run 256 frames: frame_count wraps 255 -> 0, and frame_start fires on every frame.
REQ-044 Assert reset_n=0 for 3 clk at hcount=700, vcount=491: all outputs take their reset values asynchronously, and the restart matches REQ-040.
REQ-045 CLK_DIV=1 with H/V parameters 8/2/2/2 and 4/1/1/1: pix_tick stays 1; the line is 14 clk; hsync=0 at hcount 10..11; frame_start repeats every 98 clk.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing outputs of the VGA sync generator.
//   master : driven by vga_sync_gen
//   slave  : consumed by pixel pipelines / testbenches
// Signals:
//   pix_tick    first clk cycle of each new pixel position
//   hcount      horizontal position (10 bit)
//   vcount      vertical position (10 bit)
//   hsync       horizontal sync, active low
//   vsync       vertical sync, active low
//   video_on    current position is inside the visible area
//   line_start  pulse when hcount wraps to 0
//   frame_start pulse when (hcount, vcount) wrap to (0, 0)
//   frame_count completed frames, wrapping (8 bit)
interface vga_sync_gen_if;
  logic       pix_tick;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output pix_tick, hcount, vcount, hsync, vsync, video_on,
           line_start, frame_start, frame_count
  );

  modport slave (
    input  pix_tick, hcount, vcount, hsync, vsync, video_on,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA horizontal/vertical timing generator.
// A clock divider produces one pixel advance every CLK_DIV clk cycles; the
// h/v counters step on that advance and all sync/blank/pulse outputs are
// registered decodes of the next counter values, so they line up exactly
// with the counters presented in the same cycle.
// Ports:
//   clk     system clock
//   reset_n asynchronous active-low reset (forces position (0,0) outputs)
//   vga     master modport of vga_sync_gen_if carrying all timing outputs
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_sync_gen_if.master    vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

  // One extra bit so a sync window ending exactly at 1024 still compares right.
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] fc_q, fc_d;
  logic       tick_q, ls_q, fs_q;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       von_q, von_d;
  logic       adv, h_wrap, v_wrap;

  always_comb begin
    adv    = (div_q == DIV_LAST);
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);

    div_d  = adv ? '0 : div_q + 4'd1;
    h_d    = h_q;
    v_d    = v_q;
    fc_d   = fc_q;

    if (adv) begin
      if (h_wrap) begin
        h_d = '0;
        if (v_wrap) begin
          v_d  = '0;
          fc_d = fc_q + 8'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // Decode the position being loaded this edge, not the current one,
    // so the registered decode has no skew against hcount/vcount.
    hs_d  = !(({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_END));
    vs_d  = !(({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_END));
    von_d = ({1'b0, h_d} < H_VIS) && ({1'b0, v_d} < V_VIS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      fc_q   <= '0;
      tick_q <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      // Decode of position (0,0): outside both sync windows, visible.
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      von_q  <= 1'b1;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      fc_q   <= fc_d;
      tick_q <= adv;
      ls_q   <= adv & h_wrap;
      fs_q   <= adv & h_wrap & v_wrap;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      von_q  <= von_d;
    end
  end

  assign vga.pix_tick    = tick_q;
  assign vga.hcount      = h_q;
  assign vga.vcount      = v_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.video_on    = von_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: three vga_sync_gen instances (defaults; CLK_DIV=1 tiny
// raster; CLK_DIV=3 tiny raster) compared every cycle against an arithmetic
// model: after n clk edges out of reset there have been n/CLK_DIV pixel
// advances, from which position, pulses and frame count follow directly.
// Random asynchronous resets are injected on instances 0 and 2.
module tb_vga_sync_gen;

  // {CLK_DIV, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP}
  localparam longint CFG [3][9] = '{
    '{2, 640, 16, 96, 48, 480, 10, 2, 33},
    '{1,   8,  2,  2,  2,   4,  1, 1,  1},
    '{3,   6,  2,  3,  1,   3,  1, 2,  2}
  };

  logic       clk;
  logic [2:0] rst_n;
  longint     n [3];
  longint     k;
  int         checks;
  int         errors;

  vga_sync_gen_if if0 ();
  vga_sync_gen_if if1 ();
  vga_sync_gen_if if2 ();

  vga_sync_gen u0 (.clk(clk), .reset_n(rst_n[0]), .vga(if0));

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1)
  ) u1 (.clk(clk), .reset_n(rst_n[1]), .vga(if1));

  vga_sync_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(3)
  ) u2 (.clk(clk), .reset_n(rst_n[2]), .vga(if2));

  logic [33:0] vec [3];
  assign vec[0] = {if0.pix_tick, if0.hcount, if0.vcount, if0.hsync, if0.vsync,
                   if0.video_on, if0.line_start, if0.frame_start, if0.frame_count};
  assign vec[1] = {if1.pix_tick, if1.hcount, if1.vcount, if1.hsync, if1.vsync,
                   if1.video_on, if1.line_start, if1.frame_start, if1.frame_count};
  assign vec[2] = {if2.pix_tick, if2.hcount, if2.vcount, if2.hsync, if2.vsync,
                   if2.video_on, if2.line_start, if2.frame_start, if2.frame_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] model(input int i, input longint nn);
    longint d, ht, vt, ft, a, p, h, v;
    logic   tick, hs, vs, von, ls, fs;
    logic [7:0] fc;
    d   = CFG[i][0];
    ht  = CFG[i][1] + CFG[i][2] + CFG[i][3] + CFG[i][4];
    vt  = CFG[i][5] + CFG[i][6] + CFG[i][7] + CFG[i][8];
    ft  = ht * vt;
    a   = nn / d;
    p   = a % ft;
    h   = p % ht;
    v   = p / ht;
    tick = (nn > 0) && (nn % d == 0);
    ls   = tick && (h == 0);
    fs   = tick && (p == 0);
    fc   = 8'((a / ft) % 256);
    hs   = !((h >= CFG[i][1] + CFG[i][2]) && (h < CFG[i][1] + CFG[i][2] + CFG[i][3]));
    vs   = !((v >= CFG[i][5] + CFG[i][6]) && (v < CFG[i][5] + CFG[i][6] + CFG[i][7]));
    von  = (h < CFG[i][1]) && (v < CFG[i][5]);
    return {tick, 10'(h), 10'(v), hs, vs, von, ls, fs, fc};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Edge counting for the model; resets are only driven between edges.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n[i]) n[i] = n[i] + 1;
      else          n[i] = 0;
    end
    if (rst_n[1]) k = k + 1;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [33:0] e;
      logic [33:0] g;
      e = model(i, rst_n[i] ? n[i] : 0);
      g = vec[i];
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle inst%0d n=%0d got tick=%b h=%0d v=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d want tick=%b h=%0d v=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d",
                 i, n[i], g[33], g[32:23], g[22:13], g[12], g[11], g[10], g[9], g[8], g[7:0],
                 e[33], e[32:23], e[22:13], e[12], e[11], e[10], e[9], e[8], e[7:0]);
      end
    end
  end

  // Statistics for the hand-computed expectations.
  int  hs0_ticks = 0, hs0_first = -1, von0_fall = -1, ls0_k = -1, ls0_v = -1;
  int  ls1_k = -1, fs1_first = -1, fs1_second = -1, fs1_n = 0;
  int  hs1_min = 1000, hs1_max = -1, tick1_low = 0;
  int  wrap1 = 0;
  logic [7:0] prev_fc1 = '0;

  always @(negedge clk) begin
    if (k >= 1 && k <= 1600) begin
      if (if0.pix_tick && !if0.hsync) hs0_ticks++;
      if (!if0.hsync && hs0_first < 0) hs0_first = int'(if0.hcount);
      if (!if0.video_on && von0_fall < 0) von0_fall = int'(if0.hcount);
      if (if0.line_start && ls0_k < 0) begin
        ls0_k = int'(k);
        ls0_v = int'(if0.vcount);
      end
    end
    if (k >= 1) begin
      if (if1.line_start && ls1_k < 0) ls1_k = int'(k);
      if (if1.frame_start) begin
        if (fs1_first < 0)       fs1_first = int'(k);
        else if (fs1_second < 0) fs1_second = int'(k);
        fs1_n++;
      end
      if (!if1.hsync) begin
        if (int'(if1.hcount) < hs1_min) hs1_min = int'(if1.hcount);
        if (int'(if1.hcount) > hs1_max) hs1_max = int'(if1.hcount);
      end
      if (!if1.pix_tick) tick1_low++;
      if (prev_fc1 == 8'd255 && if1.frame_count == 8'd0) wrap1++;
      prev_fc1 = if1.frame_count;
    end
  end

  task automatic chk_reset0(input string tag);
    chk({tag, "_h"},    if0.hcount, 0);
    chk({tag, "_v"},    if0.vcount, 0);
    chk({tag, "_fc"},   if0.frame_count, 0);
    chk({tag, "_tick"}, if0.pix_tick, 0);
    chk({tag, "_ls"},   if0.line_start, 0);
    chk({tag, "_fs"},   if0.frame_start, 0);
    chk({tag, "_hs"},   if0.hsync, 1);
    chk({tag, "_vs"},   if0.vsync, 1);
    chk({tag, "_von"},  if0.video_on, 1);
  endtask

  initial begin
    int found;
    checks = 0;
    errors = 0;
    k      = 0;
    for (int i = 0; i < 3; i++) n[i] = 0;
    rst_n  = '0;

    repeat (3) @(posedge clk);
    #2;
    chk_reset0("por");
    rst_n = '1;

    // Restart timing at defaults and at CLK_DIV=1.
    @(posedge clk); #3;
    chk("e1_h0", if0.hcount, 0);
    chk("e1_tick0", if0.pix_tick, 0);
    chk("e1_tick1", if1.pix_tick, 1);
    chk("e1_h1", if1.hcount, 1);
    @(posedge clk); #3;
    chk("e2_h0", if0.hcount, 1);
    chk("e2_tick0", if0.pix_tick, 1);
    chk("e2_ls0", if0.line_start, 0);
    @(posedge clk); #3;
    chk("e3_tick0", if0.pix_tick, 0);

    while (k < 1700) @(posedge clk);
    chk("hs0_ticks", hs0_ticks, 96);
    chk("hs0_first", hs0_first, 656);
    chk("von0_fall", von0_fall, 640);
    chk("ls0_clk", ls0_k, 1600);
    chk("ls0_v", ls0_v, 1);
    chk("ls1_clk", ls1_k, 14);
    chk("fs1_first", fs1_first, 98);
    chk("fs1_period", fs1_second - fs1_first, 98);
    chk("hs1_min", hs1_min, 10);
    chk("hs1_max", hs1_max, 11);

    // Mid-line, mid-hsync asynchronous reset of the default instance.
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge clk);
      if (if0.hcount == 10'd700) found = 1;
    end
    chk("find_h700", found, 1);
    chk("pre_rst_hs", if0.hsync, 0);
    #1;
    rst_n[0] = 1'b0;
    n[0] = 0;
    #1;
    chk_reset0("async");
    repeat (3) @(posedge clk);
    #2;
    rst_n[0] = 1'b1;
    @(posedge clk); #3;
    chk("re1_h", if0.hcount, 0);
    chk("re1_tick", if0.pix_tick, 0);
    @(posedge clk); #3;
    chk("re2_h", if0.hcount, 1);
    chk("re2_tick", if0.pix_tick, 1);
    @(posedge clk); #3;
    chk("re3_tick", if0.pix_tick, 0);

    // Random asynchronous reset pulses on instances 0 and 2.
    for (int it = 0; it < 60; it++) begin
      int j;
      int off;
      int hold;
      j = ($urandom_range(0, 1) == 0) ? 0 : 2;
      repeat ($urandom_range(1, 400)) @(posedge clk);
      off = $urandom_range(1, 3);
      #(off);
      rst_n[j] = 1'b0;
      n[j] = 0;
      hold = $urandom_range(0, 3);
      if (hold == 0) begin
        #1;
        rst_n[j] = 1'b1;
      end else begin
        repeat (hold) @(posedge clk);
        #2;
        rst_n[j] = 1'b1;
      end
    end

    // Let the CLK_DIV=1 instance pass 256 frames without a reset.
    for (int c = 0; c < 40000 && k < 25300; c++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("run_len", (k >= 25300) ? 1 : 0, 1);
    chk("tick1_low", tick1_low, 0);
    chk("fc1_wrap", wrap1, 1);
    chk("fs1_count", fs1_n, k / 98);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
